// File: rtl/asyn_fifo.sv
// Single-clock FIFO with Gray-coded pointers and two-flop pointer synchronizers.
// The flags react pessimistically, and memory is read combinationally in first-word-fall-through style.
module asyn_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  wr_clk,
  input  logic                  wreset_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  wr_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_empty
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW-2){1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d;
  logic [PW-1:0] rbin_q, rbin_d, rgray_q, rgray_d;
  logic [PW-1:0] rsync1_wgray_q, rsync2_wgray_q;
  logic [PW-1:0] wsync1_rgray_q, wsync2_rgray_q;
  logic          full_q, full_d, empty_q, empty_d;
  logic          wr_fire, rd_fire;

  assign wr_fire = wr_en & ~full_q;
  assign rd_fire = rd_en & ~empty_q;

  always_comb begin
    wbin_d  = wbin_q + PW'(wr_fire);
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    rbin_d  = rbin_q + PW'(rd_fire);
    rgray_d = (rbin_d >> 1) ^ rbin_d;
    // Full when the write pointer is one lap ahead of the synchronized read pointer.
    full_d  = (wgray_d == (wsync2_rgray_q ^ FULL_MASK));
    empty_d = (rgray_d == rsync2_wgray_q);
  end

  always_ff @(posedge wr_clk or negedge wreset_n) begin
    if (!wreset_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      rbin_q         <= '0;
      rgray_q        <= '0;
      rsync1_wgray_q <= '0;
      rsync2_wgray_q <= '0;
      wsync1_rgray_q <= '0;
      wsync2_rgray_q <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      rbin_q         <= rbin_d;
      rgray_q        <= rgray_d;
      rsync1_wgray_q <= wgray_q;
      rsync2_wgray_q <= rsync1_wgray_q;
      wsync1_rgray_q <= rgray_q;
      wsync2_rgray_q <= wsync1_rgray_q;
      full_q         <= full_d;
      empty_q        <= empty_d;
    end
  end

  // Storage has no reset, so a pointer reset is enough to discard its contents.
  always_ff @(posedge wr_clk) begin
    if (wr_fire) begin
      mem_q[wbin_q[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  assign rd_data  = mem_q[rbin_q[ADDR_WIDTH-1:0]];
  assign wr_full  = full_q;
  assign rd_empty = empty_q;

endmodule

// File: tb/tb_asyn_fifo.sv
// Directed self-checking bench for asyn_fifo.
// It covers reset, interleaved traffic, fill and drain, flag latency, wrap with simultaneous traffic, and reset in the middle of a stream.
module tb_asyn_fifo;

  logic        wr_clk;
  logic        wreset_n;
  logic [31:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_empty;

  int testCount = 0;
  int failCount = 0;
  logic [31:0] expQ[$];

  asyn_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .wr_clk   (wr_clk),
    .wreset_n (wreset_n),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .wr_full  (wr_full),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_empty (rd_empty)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] wd, input logic re);
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
  endtask

  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic waitNotEmpty();
    for (int n = 0; n < 6 && rd_empty; n++) tick();
    checkOutput("wait_nonempty", 32'(rd_empty), 32'd0);
  endtask

  initial begin
    applyStimulus(1'b0, 32'd0, 1'b0);
    wreset_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_empty", 32'(rd_empty), 32'd1);
    checkOutput("reset_full", 32'(wr_full), 32'd0);
    wreset_n = 1'b1;
    repeat (3) tick();
    checkOutput("idle_empty", 32'(rd_empty), 32'd1);
    checkOutput("idle_full", 32'(wr_full), 32'd0);

    // Interleaved single write, then a check of the head word, then a pop.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0);
      waitNotEmpty();
      checkOutput("interleave_data", rd_data, 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0);
      checkOutput("interleave_empty", 32'(rd_empty), 32'd1);
    end
    repeat (3) tick();

    // Fill to capacity, then attempt a write while full.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0);
      tick();
      if (i == 15) checkOutput("fill_full_at15", 32'(wr_full), 32'd0);
    end
    checkOutput("fill_full_at16", 32'(wr_full), 32'd1);
    applyStimulus(1'b1, 32'd99, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("overflow_full", 32'(wr_full), 32'd1);
    checkOutput("fill_head", rd_data, 32'd1);

    // A single pop from full: the full flag clears at the third edge after the pop.
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("full_lat_e0", 32'(wr_full), 32'd1);
    tick();
    checkOutput("full_lat_e1", 32'(wr_full), 32'd1);
    tick();
    checkOutput("full_lat_e2", 32'(wr_full), 32'd1);
    tick();
    checkOutput("full_lat_e3", 32'(wr_full), 32'd0);

    for (int i = 2; i <= 16; i++) begin
      checkOutput("drain_notempty", 32'(rd_empty), 32'd0);
      checkOutput("drain_data", rd_data, 32'(i));
      applyStimulus(1'b0, 32'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0);
    end
    checkOutput("drain_last_empty", 32'(rd_empty), 32'd1);
    repeat (3) tick();
    checkOutput("drain_settled_empty", 32'(rd_empty), 32'd1);
    checkOutput("drain_settled_full", 32'(wr_full), 32'd0);

    // Eight words stored, then 24 cycles of simultaneous write and pop across the pointer wrap.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 32'(100 + k), 1'b0);
      tick();
      expQ.push_back(32'(100 + k));
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (4) tick();
    checkOutput("wrap_pre_empty", 32'(rd_empty), 32'd0);
    for (int c = 0; c < 24; c++) begin
      checkOutput("wrap_data", rd_data, expQ[0]);
      applyStimulus(1'b1, 32'(200 + c), 1'b1);
      tick();
      void'(expQ.pop_front());
      expQ.push_back(32'(200 + c));
      checkOutput("wrap_empty", 32'(rd_empty), 32'd0);
      checkOutput("wrap_full", 32'(wr_full), 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      checkOutput("wrap_drain_notempty", 32'(rd_empty), 32'd0);
      checkOutput("wrap_drain_data", rd_data, expQ[0]);
      void'(expQ.pop_front());
      applyStimulus(1'b0, 32'd0, 1'b1);
      tick();
      applyStimulus(1'b0, 32'd0, 1'b0);
    end
    checkOutput("wrap_drain_empty", 32'(rd_empty), 32'd1);

    // Reset asserted while words are stored.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b1, 32'(50 + k), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0);
    repeat (4) tick();
    checkOutput("mid_pre_empty", 32'(rd_empty), 32'd0);
    wreset_n = 1'b0;
    #1;
    checkOutput("mid_reset_empty", 32'(rd_empty), 32'd1);
    checkOutput("mid_reset_full", 32'(wr_full), 32'd0);
    tick();
    tick();
    wreset_n = 1'b1;

    // A single write into an empty FIFO: the empty flag clears at the third edge after the write.
    applyStimulus(1'b1, 32'd7, 1'b0);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("empty_lat_e0", 32'(rd_empty), 32'd1);
    tick();
    checkOutput("empty_lat_e1", 32'(rd_empty), 32'd1);
    tick();
    checkOutput("empty_lat_e2", 32'(rd_empty), 32'd1);
    tick();
    checkOutput("empty_lat_e3", 32'(rd_empty), 32'd0);
    checkOutput("post_reset_data", rd_data, 32'd7);
    applyStimulus(1'b0, 32'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput("post_reset_empty", 32'(rd_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
